// File: rtl/gh_int_priority_encode_8to3.sv
// Registered 8-to-3 priority encoder with per-source pending latches and ack handshake.
// Bit 7 is highest priority; EDGE_MASK selects rising-edge (1) or level (0) capture per bit.
module gh_int_priority_encode_8to3 #(
  parameter logic [7:0] EDGE_MASK = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq,
  input  logic [7:0] irq_en,
  input  logic       ack,
  output logic [2:0] irq_id,
  output logic       irq_valid,
  output logic       int_n,
  output logic [7:0] pending
);

  logic [7:0] irq_q;
  logic [7:0] rise;
  logic [7:0] clr;
  logic [7:0] pending_nxt;
  logic [7:0] masked;
  logic [2:0] id_nxt;

  assign rise = irq & ~irq_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    clr = '0;
    if (ack && irq_valid) clr[irq_id] = 1'b1;
  end

  // Edge bits: a new rising edge wins over a coincident clear. Level bits just follow the input.
  assign pending_nxt = (EDGE_MASK & (rise | (pending & ~clr))) | (~EDGE_MASK & irq);

  assign masked = pending & irq_en;

  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    id_nxt = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (masked[i]) id_nxt = 3'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q     <= 8'h00;
      pending   <= 8'h00;
      irq_id    <= 3'd0;
      irq_valid <= 1'b0;
      int_n     <= 1'b1;
    end else begin
      irq_q     <= irq;
      pending   <= pending_nxt;
      irq_id    <= id_nxt;
      irq_valid <= |masked;
      int_n     <= ~|masked;
    end
  end

endmodule

// File: tb/tb_gh_int_priority_encode_8to3.sv
// Directed bench for gh_int_priority_encode_8to3: an all-edge instance and a level-bit-7 instance.
module tb_gh_int_priority_encode_8to3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq, irq_en;
  logic       ack;
  logic [2:0] irq_id;
  logic       irq_valid, int_n;
  logic [7:0] pending;

  logic [7:0] irq2, en2;
  logic       ack2;
  logic [2:0] id2;
  logic       valid2, int_n2;
  logic [7:0] pending2;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  gh_int_priority_encode_8to3 dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .irq_en(irq_en), .ack(ack),
    .irq_id(irq_id), .irq_valid(irq_valid), .int_n(int_n), .pending(pending)
  );

  gh_int_priority_encode_8to3 #(.EDGE_MASK(8'h7F)) dut_lvl (
    .clk(clk), .rst_n(rst_n), .irq(irq2), .irq_en(en2), .ack(ack2),
    .irq_id(id2), .irq_valid(valid2), .int_n(int_n2), .pending(pending2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] p, input logic [2:0] id,
                           input logic v);
    check({tag, ".pending"}, pending, p);
    check({tag, ".irq_id"}, {5'd0, irq_id}, {5'd0, id});
    check({tag, ".irq_valid"}, {7'd0, irq_valid}, {7'd0, v});
    check({tag, ".int_n"}, {7'd0, int_n}, {7'd0, ~v});
  endtask

  initial begin
    rst_n = 1'b0; irq = 8'h00; irq_en = 8'h00; ack = 1'b0;
    irq2 = 8'h00; en2 = 8'hFF; ack2 = 1'b0;

    // Reset and idle
    step(); step();
    check_out("reset", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    repeat (10) step();
    check_out("idle", 8'h00, 3'd0, 1'b0);

    // Priority: bits 5 and 2
    irq_en = 8'hFF; irq = 8'h24;
    step();
    check_out("prio_k", 8'h24, 3'd0, 1'b0);
    irq = 8'h00;
    step();
    check_out("prio_k1", 8'h24, 3'd5, 1'b1);
    ack = 1'b1;
    step();
    check_out("prio_ack1", 8'h04, 3'd5, 1'b1);
    ack = 1'b0;
    step();
    check_out("prio_id2", 8'h04, 3'd2, 1'b1);
    ack = 1'b1;
    step();
    check("prio_ack2.pending", pending, 8'h00);
    ack = 1'b0;
    step();
    check_out("prio_empty", 8'h00, 3'd0, 1'b0);

    // Masking never clears pending
    irq_en = 8'h0F; irq = 8'h40;
    step();
    check("mask.pending", pending, 8'h40);
    irq = 8'h00;
    step();
    check_out("masked", 8'h40, 3'd0, 1'b0);
    irq_en = 8'hFF;
    step();
    check_out("unmasked", 8'h40, 3'd6, 1'b1);
    ack = 1'b1; step(); ack = 1'b0; step();
    check_out("mask_clear", 8'h00, 3'd0, 1'b0);

    // Set/clear collision on bit 3
    irq = 8'h08; step();
    irq = 8'h00; step();
    check_out("coll_pre", 8'h08, 3'd3, 1'b1);
    ack = 1'b1; irq = 8'h08;
    step();
    check("coll.pending", pending, 8'h08);
    ack = 1'b0; irq = 8'h00;
    step();
    check_out("coll_post", 8'h08, 3'd3, 1'b1);
    // Held-high input does not re-set: clear with irq low
    ack = 1'b1; step(); ack = 1'b0; step();
    check_out("coll_clear", 8'h00, 3'd0, 1'b0);

    // Level mode on bit 7 (second instance), bit 0 edge
    irq2 = 8'h81;
    step();
    check("lvl.pending", pending2, 8'h81);
    irq2 = 8'h80;
    step();
    check("lvl.id", {5'd0, id2}, 8'd7);
    ack2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("lvl_ack.id", {5'd0, id2}, 8'd7);
      check("lvl_ack.pending", pending2, 8'h81);
    end
    ack2 = 1'b0; irq2 = 8'h00;
    step();
    check("lvl_deassert.pending", pending2, 8'h01);
    check("lvl_deassert.id", {5'd0, id2}, 8'd7);
    step();
    check("lvl_next.id", {5'd0, id2}, 8'd0);
    check("lvl_next.valid", {7'd0, valid2}, 8'd1);
    check("lvl_next.int_n", {7'd0, int_n2}, 8'd0);

    // Reset mid-operation with coincident ack, irq held high through reset
    irq = 8'hA5;
    step();
    check("rst_mid.pending", pending, 8'hA5);
    step();
    check_out("rst_mid_pre", 8'hA5, 3'd7, 1'b1);
    ack = 1'b1; rst_n = 1'b0;
    step();
    check_out("rst_mid", 8'h00, 3'd0, 1'b0);
    ack = 1'b0; rst_n = 1'b1;
    step();
    check_out("relatch", 8'hA5, 3'd0, 1'b0);
    step();
    check_out("relatch_enc", 8'hA5, 3'd7, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/gh_int_priority_encode_8to3.md
Name: gh_int_priority_encode_8to3

Overview:
Registered 8-to-3 priority encoder with per-source pending latches and an acknowledge handshake. It collects up to eight interrupt or event requests and reports the highest-priority enabled pending source as a 3-bit id, the inverse mapping of the UART core's 3-to-8 decoder (id 7 corresponds to bit 7). It sits in the UART core between the status and event sources and the interrupt-identification and interrupt-output logic.

Parameters:
EDGE_MASK, 8'hFF, per-bit source mode: 1 = rising-edge latched (cleared by ack), 0 = level (follows input)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous reset, active low, sampled on rising clk
irq  input  8  request inputs, bit 7 highest priority
irq_en  input  8  per-bit enable; masked bits still latch but are not encoded
ack  input  1  one-cycle acknowledge of the currently reported id
irq_id  output  3  index of highest-priority enabled pending bit (registered)
irq_valid  output  1  1 when any enabled bit is pending (registered)
int_n  output  1  active-low interrupt, equal to ~irq_valid (registered)
pending  output  8  raw pending latch contents, unmasked

Behaviour:
- Reset (rst_n=0 at a clk edge): pending=8'h00, irq_q (previous irq sample)=8'h00, irq_id=3'd0, irq_valid=0, int_n=1. Reset mid-operation discards all pending events and any coincident ack.
- Because irq_q resets to 0, an edge-mode input already high on the first edge after reset counts as a rising edge.
- irq_q <= irq on every non-reset edge.
- Edge-mode bit i (EDGE_MASK[i]=1):
  - Set when irq[i]=1 and irq_q[i]=0.
  - Cleared when ack=1, irq_valid=1 and irq_id==i.
  - Set and clear in the same cycle: set wins and the bit stays 1.
  - A held-high input does not re-set the bit after it is cleared.
- Level-mode bit i (EDGE_MASK[i]=0): pending[i] <= irq[i] every cycle. ack has no effect; the source must deassert.
- Encode stage is registered from the current pending register: with m = pending & irq_en, irq_valid <= |m, irq_id <= index of highest set bit of m, else 3'd0. int_n <= ~|m.
- Latency:
  - Input rise sampled at edge k: pending is visible after edge k; irq_id, irq_valid and int_n after edge k+1.
  - ack at edge k: the pending bit clears after k; the id or valid update follows after k+1.
- ack acts on the registered irq_id. An ack with irq_valid=0 is ignored.
- A second ack on the cycle immediately after the first targets the stale id. Clearing an already-clear bit is harmless, but if that bit re-set in the same cycle, set wins. Software and FSM users space acks by at least 2 cycles.
- irq_en changes take effect on the encode one cycle later. Masking never clears pending.
- No wrap-around or overflow. Multiple edges on one bit before ack collapse to a single pending event.

Test Plan:
- Reset and idle: rst_n=0 for 2 cycles with irq=8'h00 -> pending=8'h00, irq_id=0, irq_valid=0, int_n=1. Then irq=8'h00 for 10 cycles -> outputs unchanged.
- Priority: irq_en=8'hFF, pulse irq=8'h24 for 1 cycle -> pending=8'h24 after edge k, irq_id=5, irq_valid=1 and int_n=0 after edge k+1. ack -> irq_id=2 two edges later. ack again -> pending=8'h00, irq_valid=0, int_n=1.
- Masking: irq_en=8'h0F, pulse irq[6] -> pending=8'h40, irq_valid=0. Set irq_en=8'hFF -> irq_id=6 and irq_valid=1 one cycle later.
- Set/clear collision: bit 3 pending and reported. Assert ack in the same cycle as a new rising edge on irq[3] -> pending[3] stays 1 and irq_id stays 3.
- Level mode (EDGE_MASK=8'h7F): hold irq[7]=1, ack repeatedly -> irq_id stays 7. Deassert irq[7] -> pending[7]=0 the next edge, and the next-priority pending id is reported one edge later.
- Reset mid-operation: pending=8'hA5, irq_id=7, assert rst_n=0 with a coincident ack -> all outputs at reset values. Keep irq high through reset on edge bits 0, 2, 5 and 7 -> those bits re-latch on the first post-reset edge.
